// File: rtl/riscv_lsu.sv
// RV32I load/store unit: validates a core memory request, drives one cache access
// with a stall timeout, and returns the sign/zero-extended load result.
module riscv_lsu #(
  parameter int ADDR_W   = 12,
  parameter int MAX_WAIT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lsu_valid,
  input  logic              lsu_is_store,
  input  logic [2:0]        lsu_funct3,
  input  logic [31:0]       lsu_addr,
  input  logic [31:0]       lsu_wdata,
  output logic              lsu_stall,
  output logic [31:0]       lsu_rdata,
  output logic              lsu_done,
  output logic              lsu_err,
  output logic [ADDR_W-1:0] Data_addr,
  output logic [1:0]        we,
  output logic [1:0]        re,
  output logic [31:0]       Wdata,
  input  logic [31:0]       Rdata,
  input  logic              Stall
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [15:0] WAIT_LAST = 16'(MAX_WAIT - 1);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [2:0]        funct3_q;
  logic              is_store_q;
  logic              err_q;
  logic [15:0]       wait_cnt;

  logic              req_err;
  logic [1:0]        size;
  logic [31:0]       load_ext;
  logic [31:0]       store_data;
  logic              in_access;

  always_comb begin
    req_err = 1'b0;
    case (lsu_funct3[1:0])
      2'b01:   if (lsu_addr[0]) req_err = 1'b1;
      2'b10:   if (lsu_addr[1:0] != 2'b00) req_err = 1'b1;
      default: ;
    endcase
    if (lsu_is_store) begin
      if (lsu_funct3 >= 3'b011) req_err = 1'b1;
    end else if (lsu_funct3 == 3'b011 || lsu_funct3[2:1] == 2'b11) begin
      req_err = 1'b1;
    end
    if ((lsu_addr >> ADDR_W) != 32'd0) req_err = 1'b1;
  end

  // funct3[1:0] = 11 never reaches ACCESS, so it folds into the word case
  always_comb begin
    case (funct3_q[1:0])
      2'b00:   size = 2'd1;
      2'b01:   size = 2'd2;
      default: size = 2'd3;
    endcase
  end

  always_comb begin
    case (funct3_q)
      3'b000:  load_ext = {{24{Rdata[7]}}, Rdata[7:0]};
      3'b001:  load_ext = {{16{Rdata[15]}}, Rdata[15:0]};
      3'b100:  load_ext = {24'd0, Rdata[7:0]};
      3'b101:  load_ext = {16'd0, Rdata[15:0]};
      default: load_ext = Rdata;
    endcase
  end

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   store_data = {24'd0, wdata_q[7:0]};
      2'b01:   store_data = {16'd0, wdata_q[15:0]};
      default: store_data = wdata_q;
    endcase
  end

  assign in_access = (state == ACCESS);
  assign re        = (in_access && !is_store_q) ? size : 2'd0;
  assign we        = (in_access &&  is_store_q) ? size : 2'd0;
  assign Data_addr = in_access ? addr_q : '0;
  assign Wdata     = (in_access && is_store_q) ? store_data : 32'd0;
  assign lsu_done  = (state == DONE);
  assign lsu_err   = lsu_done && err_q;
  assign lsu_rdata = rdata_q;
  assign lsu_stall = lsu_valid && (state != DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      funct3_q   <= '0;
      is_store_q <= 1'b0;
      err_q      <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (lsu_valid) begin
            addr_q     <= lsu_addr[ADDR_W-1:0];
            wdata_q    <= lsu_wdata;
            funct3_q   <= lsu_funct3;
            is_store_q <= lsu_is_store;
            wait_cnt   <= '0;
            if (req_err) begin
              err_q   <= 1'b1;
              rdata_q <= '0;
              state   <= DONE;
            end else begin
              err_q <= 1'b0;
              state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (!Stall) begin
            rdata_q <= is_store_q ? 32'd0 : load_ext;
            state   <= DONE;
          end else if (wait_cnt == WAIT_LAST) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
            state   <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu (ADDR_W=12, MAX_WAIT=4) with hand-computed expectations.
module tb_riscv_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        lsu_valid;
  logic        lsu_is_store;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic        lsu_stall;
  logic [31:0] lsu_rdata;
  logic        lsu_done;
  logic        lsu_err;
  logic [11:0] Data_addr;
  logic [1:0]  we;
  logic [1:0]  re;
  logic [31:0] Wdata;
  logic [31:0] Rdata;
  logic        Stall;

  int n_cmp = 0;
  int n_err = 0;
  int n_re;
  int guard;

  riscv_lsu #(.ADDR_W(12), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset), .lsu_valid(lsu_valid), .lsu_is_store(lsu_is_store),
    .lsu_funct3(lsu_funct3), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_stall(lsu_stall), .lsu_rdata(lsu_rdata), .lsu_done(lsu_done), .lsu_err(lsu_err),
    .Data_addr(Data_addr), .we(we), .re(re), .Wdata(Wdata), .Rdata(Rdata), .Stall(Stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    lsu_is_store = st;
    lsu_funct3   = f3;
    lsu_addr     = a;
    lsu_wdata    = wd;
    lsu_valid    = 1'b1;
  endtask

  initial begin
    reset = 1'b0; lsu_valid = 1'b0; lsu_is_store = 1'b0; lsu_funct3 = 3'd0;
    lsu_addr = 32'd0; lsu_wdata = 32'd0; Rdata = 32'd0; Stall = 1'b0;
    #2;
    chk("rst_re", 32'(re), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_data_addr", 32'(Data_addr), 32'd0);
    chk("rst_wdata", Wdata, 32'd0);
    chk("rst_done", 32'(lsu_done), 32'd0);
    chk("rst_err", 32'(lsu_err), 32'd0);
    chk("rst_rdata", lsu_rdata, 32'd0);
    lsu_valid = 1'b1; #1;
    chk("rst_stall_follows_valid", 32'(lsu_stall), 32'd1);
    lsu_valid = 1'b0; #1;
    chk("rst_stall_low", 32'(lsu_stall), 32'd0);
    repeat (2) @(posedge clk);
    #4 reset = 1'b1;

    // lb 0x004, Rdata 0x80 -> 0xFFFFFF80 in cycle 2
    req(1'b0, 3'b000, 32'h004, 32'h0); Rdata = 32'h0000_0080; Stall = 1'b0; #1;
    chk("lb_c0_stall", 32'(lsu_stall), 32'd1);
    chk("lb_c0_re", 32'(re), 32'd0);
    tick();
    chk("lb_c1_re", 32'(re), 32'd1);
    chk("lb_c1_addr", 32'(Data_addr), 32'h004);
    chk("lb_c1_stall", 32'(lsu_stall), 32'd1);
    chk("lb_c1_done", 32'(lsu_done), 32'd0);
    chk("lb_c1_we", 32'(we), 32'd0);
    tick();
    chk("lb_c2_done", 32'(lsu_done), 32'd1);
    chk("lb_c2_err", 32'(lsu_err), 32'd0);
    chk("lb_c2_rdata", lsu_rdata, 32'hFFFF_FF80);
    chk("lb_c2_stall", 32'(lsu_stall), 32'd0);
    chk("lb_c2_re", 32'(re), 32'd0);
    lsu_valid = 1'b0; tick();
    chk("lb_idle_done", 32'(lsu_done), 32'd0);
    chk("lb_idle_rdata_hold", lsu_rdata, 32'hFFFF_FF80);

    // sh 0x00A with 3 stalled cycles; operands scrambled mid-access
    req(1'b1, 3'b001, 32'h00A, 32'h1234_5678); Stall = 1'b1; Rdata = 32'hDEAD_BEEF;
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk($sformatf("sh_c%0d_we", c), 32'(we), 32'd2);
      chk($sformatf("sh_c%0d_wdata", c), Wdata, 32'h0000_5678);
      chk($sformatf("sh_c%0d_addr", c), 32'(Data_addr), 32'h00A);
      chk($sformatf("sh_c%0d_re", c), 32'(re), 32'd0);
      chk($sformatf("sh_c%0d_done", c), 32'(lsu_done), 32'd0);
      if (c == 2) begin lsu_addr = 32'h0; lsu_wdata = 32'hFFFF_FFFF; lsu_funct3 = 3'b010; end
      if (c == 4) Stall = 1'b0;
    end
    tick();
    chk("sh_c5_done", 32'(lsu_done), 32'd1);
    chk("sh_c5_err", 32'(lsu_err), 32'd0);
    chk("sh_c5_rdata", lsu_rdata, 32'd0);
    chk("sh_c5_we", 32'(we), 32'd0);
    chk("sh_c5_wdata", Wdata, 32'd0);
    lsu_valid = 1'b0; tick();

    // sb 0x003
    req(1'b1, 3'b000, 32'h003, 32'hAABB_CCDD); tick();
    chk("sb_we", 32'(we), 32'd1);
    chk("sb_wdata", Wdata, 32'h0000_00DD);
    chk("sb_addr", 32'(Data_addr), 32'h003);
    tick();
    chk("sb_done", 32'(lsu_done), 32'd1);
    lsu_valid = 1'b0; tick();

    // lh 0x002, Rdata 0x8001 -> 0xFFFF8001
    req(1'b0, 3'b001, 32'h002, 32'h0); Rdata = 32'h0000_8001; tick();
    chk("lh_re", 32'(re), 32'd2);
    tick();
    chk("lh_rdata", lsu_rdata, 32'hFFFF_8001);
    lsu_valid = 1'b0; tick();

    // lbu at top of address range, Rdata all ones -> 0xFF
    req(1'b0, 3'b100, 32'h7FF, 32'h0); Rdata = 32'hFFFF_FFFF; tick();
    chk("lbu_re", 32'(re), 32'd1);
    chk("lbu_addr", 32'(Data_addr), 32'h7FF);
    tick();
    chk("lbu_done", 32'(lsu_done), 32'd1);
    chk("lbu_rdata", lsu_rdata, 32'h0000_00FF);

    // back-to-back: valid held high, next request is misaligned lw 0x006
    lsu_funct3 = 3'b010; lsu_addr = 32'h006; tick();
    chk("b2b_idle_done", 32'(lsu_done), 32'd0);
    chk("b2b_idle_stall", 32'(lsu_stall), 32'd1);
    chk("b2b_idle_re", 32'(re), 32'd0);
    tick();
    chk("lw_mis_done", 32'(lsu_done), 32'd1);
    chk("lw_mis_err", 32'(lsu_err), 32'd1);
    chk("lw_mis_rdata", lsu_rdata, 32'd0);
    chk("lw_mis_re", 32'(re), 32'd0);
    chk("lw_mis_we", 32'(we), 32'd0);
    lsu_valid = 1'b0; tick();

    // lhu beyond 12-bit range
    req(1'b0, 3'b101, 32'h1000, 32'h0); #1;
    chk("lhu_oor_c0_re", 32'(re), 32'd0);
    tick();
    chk("lhu_oor_done", 32'(lsu_done), 32'd1);
    chk("lhu_oor_err", 32'(lsu_err), 32'd1);
    chk("lhu_oor_re", 32'(re), 32'd0);
    lsu_valid = 1'b0; tick();

    // illegal funct3 for load and for store
    req(1'b0, 3'b011, 32'h0, 32'h0); tick();
    chk("ld_f3_011_err", 32'(lsu_err), 32'd1);
    lsu_valid = 1'b0; tick();
    req(1'b1, 3'b011, 32'h0, 32'h0); tick();
    chk("st_f3_011_err", 32'(lsu_err), 32'd1);
    chk("st_f3_011_we", 32'(we), 32'd0);
    lsu_valid = 1'b0; tick();

    // lw 0x008
    req(1'b0, 3'b010, 32'h008, 32'h0); Rdata = 32'h1234_5678; tick();
    chk("lw_re", 32'(re), 32'd3);
    tick();
    chk("lw_rdata", lsu_rdata, 32'h1234_5678);
    chk("lw_err", 32'(lsu_err), 32'd0);
    lsu_valid = 1'b0; tick();

    // timeout with MAX_WAIT=4
    req(1'b0, 3'b010, 32'h010, 32'h0); Stall = 1'b1; n_re = 0; guard = 0;
    tick();
    while (!lsu_done && guard < 20) begin
      if (re == 2'd3) n_re++;
      guard++;
      tick();
    end
    chk("to_done", 32'(lsu_done), 32'd1);
    chk("to_err", 32'(lsu_err), 32'd1);
    chk("to_re_cycles", 32'(n_re), 32'd4);
    chk("to_rdata", lsu_rdata, 32'd0);
    lsu_valid = 1'b0; Stall = 1'b0; tick();
    chk("to_idle_done", 32'(lsu_done), 32'd0);

    // reset during 2nd ACCESS cycle of lw
    req(1'b0, 3'b010, 32'h020, 32'h0); Stall = 1'b1; tick();
    chk("rm_c1_re", 32'(re), 32'd3);
    tick();
    #2 reset = 1'b0; #1;
    chk("rm_re", 32'(re), 32'd0);
    chk("rm_addr", 32'(Data_addr), 32'd0);
    chk("rm_done", 32'(lsu_done), 32'd0);
    lsu_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk($sformatf("rm_hold%0d_done", c), 32'(lsu_done), 32'd0);
    end
    #3 reset = 1'b1;
    Stall = 1'b0; Rdata = 32'hCAFE_F00D;
    req(1'b0, 3'b010, 32'h024, 32'h0); tick();
    chk("post_rst_re", 32'(re), 32'd3);
    chk("post_rst_addr", 32'(Data_addr), 32'h024);
    tick();
    chk("post_rst_done", 32'(lsu_done), 32'd1);
    chk("post_rst_err", 32'(lsu_err), 32'd0);
    chk("post_rst_rdata", lsu_rdata, 32'hCAFE_F00D);
    lsu_valid = 1'b0; tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
